// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller of the 5-stage RISC-V
// pipeline: forwarding select encodings, the load encoding of ResultSrc and
// the state type of the data-memory wait FSM.
package hazard_ctrl_pkg;

    // Operand forwarding selects (ForwardAE / ForwardBE)
    localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
    localparam logic [1:0] FWD_W    = 2'b01;  // result from W stage
    localparam logic [1:0] FWD_M    = 2'b10;  // ALU result from M stage

    // ResultSrc encoding that marks a load
    localparam logic [1:0] RES_LOAD = 2'b01;

    // Data-memory wait FSM
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side - drives register indices, stage controls and
//            dmem_ready; receives forwarding selects, stall/flush enables
//            and dmem_req.
//   slave  : hazard controller side (the reverse directions).
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [REG_AW-1:0] RdM, RdW;
    logic [1:0]        ResultSrcE, ResultSrcM;
    logic              PCSrcE;
    logic              RegWriteM, RegWriteW;
    logic              MemWriteM;
    logic              dmem_ready;
    logic              dmem_req;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushW;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE, ResultSrcM, PCSrcE, RegWriteM, RegWriteW, MemWriteM,
        output dmem_ready,
        input  dmem_req, ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE, ResultSrcM, PCSrcE, RegWriteM, RegWriteW, MemWriteM,
        input  dmem_ready,
        output dmem_req, ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW
    );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl_fwd.sv
// Purely combinational data-hazard detection.
//   Rs1D/Rs2D, Rs1E/Rs2E, RdE, RdM, RdW : register indices per stage
//   ResultSrcE                          : E result select (load = RES_LOAD)
//   RegWriteM/RegWriteW                 : write enables of M and W
//   ForwardAE/ForwardBE                 : operand forwarding selects
//   lwStall                             : load-use hazard between E and D
module hazard_fwd
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        ResultSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              lwStall
);

    // x0 is hard-wired to zero, so a write to it never produces a value
    // worth forwarding.
    logic wrM, wrW;
    assign wrM = RegWriteM && (RdM != '0);
    assign wrW = RegWriteW && (RdW != '0);

    // M is the younger producer and therefore wins over W.
    assign ForwardAE = (wrM && (Rs1E == RdM)) ? FWD_M :
                       (wrW && (Rs1E == RdW)) ? FWD_W : FWD_NONE;
    assign ForwardBE = (wrM && (Rs2E == RdM)) ? FWD_M :
                       (wrW && (Rs2E == RdW)) ? FWD_W : FWD_NONE;

    // A load in E cannot forward to D's consumer in time: one bubble needed.
    assign lwStall = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));

endmodule : hazard_fwd

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RISC-V pipeline.
//   clk, reset          : clock, synchronous active-high reset
//   hz (slave modport)  : pipeline register indices/controls in; forwarding
//                         selects, stall/flush enables and the data-memory
//                         request/ready handshake
//   mem_err             : sticky, set when a memory access times out
//   stall_cnt/flush_cnt : wrapping performance counters of StallF and of
//                         FlushD|FlushE cycles
// The memory-wait FSM holds the whole pipeline while M waits on dmem_ready
// and aborts the access after TIMEOUT_CYCLES cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    hazard_ctrl_if.slave      hz,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // wcnt only has to reach TIMEOUT_CYCLES-1.
    localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    memState_t         state, stateNext;
    logic [WCNT_W-1:0] wcnt, wcntNext;

    logic memOpM;
    logic lwStall;
    logic lastWait;
    logic abort;
    logic memStall;
    logic stallFD;
    logic flushD;
    logic flushE;

    hazard_fwd #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .Rs1D       (hz.Rs1D),
        .Rs2D       (hz.Rs2D),
        .Rs1E       (hz.Rs1E),
        .Rs2E       (hz.Rs2E),
        .RdE        (hz.RdE),
        .RdM        (hz.RdM),
        .RdW        (hz.RdW),
        .ResultSrcE (hz.ResultSrcE),
        .RegWriteM  (hz.RegWriteM),
        .RegWriteW  (hz.RegWriteW),
        .ForwardAE  (hz.ForwardAE),
        .ForwardBE  (hz.ForwardBE),
        .lwStall    (lwStall)
    );

    assign memOpM   = (hz.ResultSrcM == RES_LOAD) | hz.MemWriteM;
    assign lastWait = (state == WAIT) && (wcnt == WCNT_LAST);
    assign abort    = lastWait && !hz.dmem_ready;

    // Combinational on dmem_ready, so a zero-wait access never stalls; on
    // the abort cycle the stall drops and M advances with undefined data.
    assign memStall = memOpM & ~hz.dmem_ready & ~abort;

    // A memory stall freezes E, so a pending branch flush or load-use bubble
    // is deferred and re-evaluated once the stall releases.
    assign stallFD = memStall | lwStall;
    assign flushD  = hz.PCSrcE & ~memStall;
    assign flushE  = (lwStall | hz.PCSrcE) & ~memStall;

    assign hz.dmem_req = memOpM & ~reset;
    assign hz.StallF   = stallFD;
    assign hz.StallD   = stallFD;
    assign hz.StallE   = memStall;
    assign hz.StallM   = memStall;
    assign hz.FlushW   = memStall;
    assign hz.FlushD   = flushD;
    assign hz.FlushE   = flushE;

    // NOTE: every variable is given its hold value before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext = state;
        wcntNext  = wcnt;
        case (state)
            IDLE: begin
                if (memOpM && !hz.dmem_ready) begin
                    stateNext = WAIT;
                    wcntNext  = WCNT_W'(1);
                end
            end
            WAIT: begin
                if (hz.dmem_ready || lastWait) begin
                    // Completion or timeout abort both end the access.
                    stateNext = IDLE;
                    wcntNext  = '0;
                end else begin
                    wcntNext = wcnt + WCNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                wcntNext  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= stateNext;
            wcnt      <= wcntNext;
            if (abort) begin
                mem_err <= 1'b1;
            end
            stall_cnt <= stall_cnt + CNT_W'(stallFD);
            flush_cnt <= flush_cnt + CNT_W'(flushD | flushE);
        end
    end

endmodule : hazard_ctrl
